// File: rtl/l1b_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l1b_pkg
// Description : Shared types and constants for the L1B host-bus cycle path.
// Revision    : 1.0 - initial release
// ============================================================================
package l1b_pkg;

    localparam int   HOST_AW = 16;
    localparam int   HOST_DW = 8;
    localparam logic RD      = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PHI1 = 2'd1,
        PHI2 = 2'd2
    } hsc_state_t;

endpackage
`default_nettype wire

// File: rtl/phi0_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : phi0_edge_det
// Description : Synchronises phi0/RDY/data with equal depth; phi0 edges and phase count.
// Revision    : 1.0 - initial release
// ============================================================================
module phi0_edge_det
    import l1b_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_phi0,
    input  logic               i_rdy,
    input  logic [HOST_DW-1:0] i_d,
    output logic               o_phi0_s,
    output logic               o_rdy_s,
    output logic [HOST_DW-1:0] o_d_s,
    output logic               o_fall,
    output logic               o_rise,
    output logic [7:0]         o_phase_cnt
);

    logic [SYNC_STAGES-1:0] r_phi0_sync;
    logic [SYNC_STAGES-1:0] r_rdy_sync;
    logic [HOST_DW-1:0]     r_d_sync [SYNC_STAGES];
    logic                   r_phi0_prev;
    logic [7:0]             r_phase_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phi0_sync <= '0;
            r_rdy_sync  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_d_sync[i] <= '0;
            end
            r_phi0_prev <= 1'b0;
            r_phase_cnt <= 8'd0;
        end else begin
            r_phi0_sync[0] <= i_phi0;
            r_rdy_sync[0]  <= i_rdy;
            r_d_sync[0]    <= i_d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_phi0_sync[i] <= r_phi0_sync[i-1];
                r_rdy_sync[i]  <= r_rdy_sync[i-1];
                r_d_sync[i]    <= r_d_sync[i-1];
            end
            r_phi0_prev <= o_phi0_s;
            if (o_fall || o_rise) begin
                r_phase_cnt <= 8'd0;
            end else if (r_phase_cnt != 8'hFF) begin
                r_phase_cnt <= r_phase_cnt + 8'd1;
            end
        end
    end

    assign o_phi0_s    = r_phi0_sync[SYNC_STAGES-1];
    assign o_rdy_s     = r_rdy_sync[SYNC_STAGES-1];
    assign o_d_s       = r_d_sync[SYNC_STAGES-1];
    assign o_fall      = r_phi0_prev & ~o_phi0_s;
    assign o_rise      = ~r_phi0_prev & o_phi0_s;
    assign o_phase_cnt = r_phase_cnt;

endmodule
`default_nettype wire

// File: rtl/host_bus_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : host_bus_cycle_ctrl
// Description : Replays single-byte requests as 6502-timed host cycles with RDY and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module host_bus_cycle_ctrl
    import l1b_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LATE_CYC    = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               hsclk,
    input  logic               reset,
    input  logic               req,
    input  logic [HOST_AW-1:0] req_addr,
    input  logic               req_rnw,
    input  logic [HOST_DW-1:0] req_wdata,
    input  logic               req_sync,
    output logic               ack,
    output logic [HOST_DW-1:0] rdata,
    output logic               err,
    output logic               busy,
    input  logic               bbc_phi0,
    input  logic               bbc_rdy,
    input  logic [HOST_DW-1:0] bbc_d_in,
    output logic [HOST_AW-1:0] bbc_a,
    output logic               bbc_rnw,
    output logic               bbc_sync,
    output logic [HOST_DW-1:0] bbc_d_out,
    output logic               bbc_d_oe
);

    logic               w_phi0_s, w_rdy_s, w_fall, w_rise;
    logic [HOST_DW-1:0] w_d_s;
    logic [7:0]         w_phase_cnt;

    phi0_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
        .clk         (hsclk),
        .rst         (reset),
        .i_phi0      (bbc_phi0),
        .i_rdy       (bbc_rdy),
        .i_d         (bbc_d_in),
        .o_phi0_s    (w_phi0_s),
        .o_rdy_s     (w_rdy_s),
        .o_d_s       (w_d_s),
        .o_fall      (w_fall),
        .o_rise      (w_rise),
        .o_phase_cnt (w_phase_cnt)
    );

    hsc_state_t         r_state, w_state_nxt;
    logic               r_ack, r_err, r_busy, r_bbc_rnw, r_bbc_sync, r_bbc_d_oe;
    logic [HOST_DW-1:0] r_rdata, r_bbc_d_out;
    logic [HOST_AW-1:0] r_bbc_a;
    logic [15:0]        r_tmo;

    logic               w_ack_nxt, w_err_nxt, w_busy_nxt, w_rnw_nxt, w_sync_nxt, w_oe_nxt;
    logic [HOST_DW-1:0] w_rdata_nxt, w_dout_nxt;
    logic [HOST_AW-1:0] w_a_nxt;
    logic [15:0]        w_tmo_nxt;
    logic               w_start, w_tmo_hit;

    // r_ack blocks a restart from the request that is still held during its own ack cycle
    assign w_start   = req && !r_ack && (w_fall || (!w_phi0_s && (w_phase_cnt < 8'(LATE_CYC))));
    assign w_tmo_hit = r_busy && (r_tmo == 16'(TIMEOUT_CYC - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_busy_nxt  = r_busy;
        w_rdata_nxt = r_rdata;
        w_a_nxt     = r_bbc_a;
        w_rnw_nxt   = r_bbc_rnw;
        w_sync_nxt  = r_bbc_sync;
        w_dout_nxt  = r_bbc_d_out;
        w_oe_nxt    = r_bbc_d_oe;
        w_tmo_nxt   = r_busy ? (r_tmo + 16'd1) : r_tmo;

        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_a_nxt     = req_addr;
                    w_rnw_nxt   = req_rnw;
                    w_sync_nxt  = req_sync;
                    w_dout_nxt  = req_wdata;
                    w_busy_nxt  = 1'b1;
                    w_tmo_nxt   = 16'd0;
                    w_state_nxt = PHI1;
                end
            end
            PHI1, PHI2: begin
                if (w_tmo_hit) begin
                    w_ack_nxt   = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_rdata_nxt = 8'hFF;
                    w_oe_nxt    = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_rnw_nxt   = RD;
                    w_sync_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else if (r_state == PHI1) begin
                    if (w_rise) begin
                        w_state_nxt = PHI2;
                        if (r_bbc_rnw != RD) begin
                            w_oe_nxt = 1'b1;
                        end
                    end
                end else if (w_fall) begin
                    if (r_bbc_rnw == RD && !w_rdy_s) begin
                        w_state_nxt = PHI1;
                    end else begin
                        if (r_bbc_rnw == RD) begin
                            w_rdata_nxt = w_d_s;
                        end
                        w_ack_nxt   = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_oe_nxt    = 1'b0;
                        w_rnw_nxt   = RD;
                        w_sync_nxt  = 1'b0;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge hsclk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_rdata     <= '0;
            r_bbc_a     <= '0;
            r_bbc_rnw   <= RD;
            r_bbc_sync  <= 1'b0;
            r_bbc_d_out <= '0;
            r_bbc_d_oe  <= 1'b0;
            r_tmo       <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_ack       <= w_ack_nxt;
            r_err       <= w_err_nxt;
            r_busy      <= w_busy_nxt;
            r_rdata     <= w_rdata_nxt;
            r_bbc_a     <= w_a_nxt;
            r_bbc_rnw   <= w_rnw_nxt;
            r_bbc_sync  <= w_sync_nxt;
            r_bbc_d_out <= w_dout_nxt;
            r_bbc_d_oe  <= w_oe_nxt;
            r_tmo       <= w_tmo_nxt;
        end
    end

    assign ack       = r_ack;
    assign err       = r_err;
    assign busy      = r_busy;
    assign rdata     = r_rdata;
    assign bbc_a     = r_bbc_a;
    assign bbc_rnw   = r_bbc_rnw;
    assign bbc_sync  = r_bbc_sync;
    assign bbc_d_out = r_bbc_d_out;
    assign bbc_d_oe  = r_bbc_d_oe;

endmodule
`default_nettype wire

// File: tb/tb_host_bus_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_host_bus_cycle_ctrl
// Description : Directed scoreboard bench for host_bus_cycle_ctrl; phi0 = hsclk/32.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_host_bus_cycle_ctrl;

    localparam int SYNC_STAGES = 2;
    localparam int LATE_CYC    = 4;
    localparam int TIMEOUT_CYC = 1024;

    logic        hsclk     = 1'b0;
    logic        reset     = 1'b1;
    logic        req       = 1'b0;
    logic [15:0] req_addr  = 16'h0000;
    logic        req_rnw   = 1'b1;
    logic [7:0]  req_wdata = 8'h00;
    logic        req_sync  = 1'b0;
    logic        bbc_phi0  = 1'b0;
    logic        bbc_rdy   = 1'b1;
    logic [7:0]  bbc_d_in  = 8'h00;
    logic        ack, err, busy, bbc_rnw, bbc_sync, bbc_d_oe;
    logic [7:0]  rdata, bbc_d_out;
    logic [15:0] bbc_a;

    host_bus_cycle_ctrl #(
        .SYNC_STAGES (SYNC_STAGES),
        .LATE_CYC    (LATE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .hsclk     (hsclk),
        .reset     (reset),
        .req       (req),
        .req_addr  (req_addr),
        .req_rnw   (req_rnw),
        .req_wdata (req_wdata),
        .req_sync  (req_sync),
        .ack       (ack),
        .rdata     (rdata),
        .err       (err),
        .busy      (busy),
        .bbc_phi0  (bbc_phi0),
        .bbc_rdy   (bbc_rdy),
        .bbc_d_in  (bbc_d_in),
        .bbc_a     (bbc_a),
        .bbc_rnw   (bbc_rnw),
        .bbc_sync  (bbc_sync),
        .bbc_d_out (bbc_d_out),
        .bbc_d_oe  (bbc_d_oe)
    );

    always #5 hsclk = ~hsclk;

    // Host model: phi0 toggles every 16 hsclk, 2 time units after posedge.
    // stall_hi freezes phi0 once it is high; RDY is held low until mid-phi1 after fall rdy_rel.
    int phi_cnt  = 0;
    int n_fall   = 0;
    int rdy_rel  = -1;
    bit stall_hi = 1'b0;

    always @(posedge hsclk) begin
        #2;
        if (!(stall_hi && bbc_phi0)) begin
            phi_cnt++;
            if (phi_cnt == 16) begin
                phi_cnt  = 0;
                bbc_phi0 = ~bbc_phi0;
                if (!bbc_phi0) n_fall++;
            end
        end
        bbc_rdy = (n_fall > rdy_rel) || (n_fall == rdy_rel && (bbc_phi0 || phi_cnt >= 8));
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic       chk_d;
        logic [7:0] d;
        logic       e;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t mk_exp(input logic chk_d, input logic [7:0] d, input logic e);
        exp_t x;
        x.chk_d = chk_d;
        x.d     = d;
        x.e     = e;
        return x;
    endfunction

    task automatic tick();
        exp_t x;
        @(negedge hsclk);
        if (ack === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_ack", 32'(ack), 32'd0);
            end else begin
                x = sb.pop_front();
                check("ack_err", 32'(err), 32'(x.e));
                if (x.chk_d) check("ack_rdata", 32'(rdata), 32'(x.d));
            end
        end
    endtask

    task automatic wait_phase(input logic lvl, input int cnt);
        int k;
        k = 0;
        while (!(bbc_phi0 === lvl && phi_cnt == cnt) && k < 200) begin
            tick();
            k++;
        end
        if (k >= 200) check("wait_phase_bound", 32'(k), 32'd0);
    endtask

    // Issue one request and follow it to its ack, gathering bus statistics.
    task automatic run_txn(input logic [15:0] a, input logic rnw, input logic [7:0] wd,
                           input logic sy, input exp_t ex,
                           output int busy_n, output int oe_n, output int falls,
                           output int bus_bad, output int ack_at, output bit got);
        int f0;
        int k;
        f0 = n_fall;
        k  = 0;
        busy_n = 0; oe_n = 0; bus_bad = 0; ack_at = -1; got = 1'b0;
        req_addr = a; req_rnw = rnw; req_wdata = wd; req_sync = sy; req = 1'b1;
        sb.push_back(ex);
        while (!got && k < 3000) begin
            tick();
            k++;
            if (busy === 1'b1) begin
                busy_n++;
                if (bbc_a !== a || bbc_rnw !== rnw || bbc_sync !== sy) bus_bad++;
            end
            if (bbc_d_oe === 1'b1) begin
                oe_n++;
                if (bbc_d_out !== wd) bus_bad++;
            end
            if (ack === 1'b1) begin
                got    = 1'b1;
                ack_at = bbc_phi0 ? 100 + phi_cnt : phi_cnt;
            end
        end
        req   = 1'b0;
        falls = n_fall - f0;
        if (!got) void'(sb.pop_back());
        check("ack_seen", 32'(got), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  bn, on, fl, bad, at, k;
        bit  got;
        bit  same;
        int  pt [4];
        pt = '{2, 3, 4, 6};

        // Power-on reset state
        repeat (4) tick();
        check("rst_ack",   32'(ack),       32'd0);
        check("rst_err",   32'(err),       32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_rdata", 32'(rdata),     32'h00);
        check("rst_a",     32'(bbc_a),     32'h0000);
        check("rst_rnw",   32'(bbc_rnw),   32'd1);
        check("rst_sync",  32'(bbc_sync),  32'd0);
        check("rst_dout",  32'(bbc_d_out), 32'h00);
        check("rst_oe",    32'(bbc_d_oe),  32'd0);
        reset = 1'b0;

        // 1: reset in the middle of a write with the data bus driven
        wait_phase(1'b0, 1);
        req_addr = 16'h1234; req_rnw = 1'b0; req_wdata = 8'h55; req_sync = 1'b0; req = 1'b1;
        k = 0;
        while (bbc_d_oe !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        check("t1_oe_before_reset", 32'(bbc_d_oe), 32'd1);
        reset = 1'b1;
        req   = 1'b0;
        tick();
        check("t1_oe",   32'(bbc_d_oe), 32'd0);
        check("t1_rnw",  32'(bbc_rnw),  32'd1);
        check("t1_a",    32'(bbc_a),    32'h0000);
        check("t1_ack",  32'(ack),      32'd0);
        check("t1_busy", 32'(busy),     32'd0);
        reset = 1'b0;
        repeat (40) tick();

        // 2: read raised mid-phi2 waits for the fall
        bbc_d_in = 8'h5A;
        wait_phase(1'b1, 8);
        run_txn(16'hFE40, 1'b1, 8'h00, 1'b0, mk_exp(1'b1, 8'h5A, 1'b0), bn, on, fl, bad, at, got);
        check("t2_busy_cycles", bn, 32);
        check("t2_falls", fl, 2);
        check("t2_ack_phase", at, SYNC_STAGES + 1);
        check("t2_bus", bad, 0);

        // 3: opcode-tagged write
        wait_phase(1'b0, 1);
        run_txn(16'h3000, 1'b0, 8'hA5, 1'b1, mk_exp(1'b0, 8'h00, 1'b0), bn, on, fl, bad, at, got);
        check("t3_busy_cycles", bn, 32);
        check("t3_oe_cycles", on, 16);
        check("t3_falls", fl, 1);
        check("t3_ack_phase", at, SYNC_STAGES + 1);
        check("t3_bus", bad, 0);
        check("t3_oe_at_ack", 32'(bbc_d_oe), 32'd0);
        check("t3_sync_idle", 32'(bbc_sync), 32'd0);
        check("t3_rnw_idle",  32'(bbc_rnw),  32'd1);

        // 4: RDY low across two host cycles
        bbc_d_in = 8'h3C;
        wait_phase(1'b0, 1);
        rdy_rel = n_fall + 2;
        run_txn(16'h8000, 1'b1, 8'h00, 1'b0, mk_exp(1'b1, 8'h3C, 1'b0), bn, on, fl, bad, at, got);
        check("t4_busy_cycles", bn, 96);
        check("t4_falls", fl, 3);
        check("t4_ack_phase", at, SYNC_STAGES + 1);
        check("t4_bus", bad, 0);
        rdy_rel = -1;
        repeat (4) tick();

        // 5a: late-start window after a fall (DUT phase_cnt = phi_cnt - 3)
        foreach (pt[i]) begin
            same     = (pt[i] < LATE_CYC);
            bbc_d_in = 8'h10 + 8'(i);
            wait_phase(1'b0, pt[i] + SYNC_STAGES + 1);
            run_txn(16'h0100 + 16'(i), 1'b1, 8'h00, 1'b0, mk_exp(1'b1, 8'h10 + 8'(i), 1'b0),
                    bn, on, fl, bad, at, got);
            check($sformatf("t5_busy_p%0d", pt[i]), bn, same ? 31 - pt[i] : 32);
            check($sformatf("t5_falls_p%0d", pt[i]), fl, same ? 1 : 2);
            check($sformatf("t5_ackph_p%0d", pt[i]), at, SYNC_STAGES + 1);
        end

        // 5b: back-to-back read then write
        bbc_d_in = 8'h77;
        wait_phase(1'b0, 1);
        run_txn(16'h2000, 1'b1, 8'h00, 1'b0, mk_exp(1'b1, 8'h77, 1'b0), bn, on, fl, bad, at, got);
        check("t5b_rd_falls", fl, 1);
        tick();
        run_txn(16'h2001, 1'b0, 8'h88, 1'b0, mk_exp(1'b0, 8'h00, 1'b0), bn, on, fl, bad, at, got);
        check("t5b_wr_falls", fl, 1);
        check("t5b_wr_busy", bn, 30);
        check("t5b_wr_oe", on, 16);
        check("t5b_wr_bus", bad, 0);

        // 6: phi0 stuck high during a write, then recovery
        wait_phase(1'b0, 1);
        stall_hi = 1'b1;
        run_txn(16'h4000, 1'b0, 8'h99, 1'b0, mk_exp(1'b1, 8'hFF, 1'b1), bn, on, fl, bad, at, got);
        check("t6_busy_cycles", bn, TIMEOUT_CYC);
        check("t6_falls", fl, 0);
        check("t6_oe_at_ack", 32'(bbc_d_oe), 32'd0);
        check("t6_bus", bad, 0);
        stall_hi = 1'b0;
        bbc_d_in = 8'hC3;
        wait_phase(1'b0, 1);
        run_txn(16'h4001, 1'b1, 8'h00, 1'b0, mk_exp(1'b1, 8'hC3, 1'b0), bn, on, fl, bad, at, got);
        check("t6_rec_busy", bn, 32);
        check("t6_rec_falls", fl, 1);
        check("t6_rec_ackph", at, SYNC_STAGES + 1);
        repeat (40) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
